dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address and data width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, storage depth in 32-bit words, a power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states between accept and response, range 0..15.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  CPU request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_write  input  1  1=store, 0=load.
REQ-009 SHALL have port req_mode  input  1  0=word, 1=byte; same meaning as the CPU mode signal.
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have port req_wdata  input  ADDR_WIDTH  store data; byte stores use bits [7:0].
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  CPU accepts the response.
REQ-014 SHALL have port rsp_rdata  output  ADDR_WIDTH  load data; 0 for stores.
REQ-015 SHALL have port rsp_err  output  1  misaligned-access error flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a clk edge when state is IDLE and req_valid=1, capturing write, mode, addr and wdata.
REQ-019 SHALL, on accept, go to WAIT when WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else directly to RESP.
REQ-020 SHALL decrement the counter in WAIT and go to RESP on the edge where the counter is 0.
REQ-021 SHALL assert rsp_valid the first cycle after accept plus WAIT_CYCLES, i.e. latency WAIT_CYCLES+1.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a new request in the cycle it leaves RESP; req_ready rises the following cycle.
REQ-024 SHALL form the word index from addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4 bytes.
REQ-025 SHALL commit stores on the edge entering RESP, exactly once per request.
REQ-026 SHALL write all 32 bits for word stores, and only byte lane addr[1:0] (little-endian) for byte stores.
REQ-027 SHALL return the full word for word loads, and lane addr[1:0] zero-extended to 32 bits for byte loads.
REQ-028 SHALL make a load issued after a store to the same address return the stored value.

Reset
REQ-029 SHALL, on rst=0 asynchronously, force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while rst=0.
REQ-030 SHALL abandon an in-flight request on reset mid-transaction; an uncommitted store is never written.
REQ-031 SHALL NOT reset storage contents.

Configuration
REQ-032 SHALL, with DMEM_MISALIGN_CHECK_EN defined, flag word accesses with addr[1:0]!=0 by setting rsp_err=1 and rsp_rdata=0 and suppressing the store, with unchanged latency.
REQ-033 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore addr[1:0] for word accesses and tie rsp_err to 0.

Structure
REQ-034 SHALL place FSM state encodings and the MODE_WORD/MODE_BYTE constants in the shared parameters package, alongside ADDR_WIDTH.
REQ-035 SHALL implement storage in one sub-module, dmem_array: synchronous write with a 4-bit byte-enable and combinational read.

Verification
REQ-036 SHALL cover: word store 0xDEADBEEF @0x10, then word load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
REQ-037 SHALL cover: byte store 0xAA @0x13 over word 0x11223344 @0x10, then word load @0x10 -> 0xAA223344; byte load @0x13 -> 0x000000AA.
REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout, one store commit only.
REQ-039 SHALL cover: store 0x5 @0x400 (DEPTH_WORDS=256), then load @0x0 -> 0x5 (wrap); WAIT_CYCLES=0 -> latency 1.
REQ-040 SHALL cover: rst pulsed low during WAIT of a store 0x77 @0x20 -> rsp_valid=0 immediately, state IDLE, later load @0x20 returns prior value.
REQ-041 SHALL cover: word store @0x22 -> with DMEM_MISALIGN_CHECK_EN, rsp_err=1 and memory unchanged; without it, rsp_err=0 and word @0x20 is written.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and types for the data-memory responder
//
// Purpose: FSM state encoding, access-mode constants and the default address/data
// width shared by dmem_responder and dmem_array.
// Contents:
//   ADDR_WIDTH       default byte-address and data width
//   WORD_BITS        storage word width
//   MODE_WORD/BYTE   encoding of req_mode
//   state_t          responder FSM states
//   byte_enable()    one-hot lane enable for a byte access
`timescale 1ns/1ps

package dmem_responder_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int WORD_BITS  = 32;

  localparam logic MODE_WORD = 1'b0;
  localparam logic MODE_BYTE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] byte_enable(input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    be[lane] = 1'b1;
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-organised data storage with byte enables
//
// Purpose: DEPTH_WORDS x 32-bit storage. Writes are synchronous on the rising
// edge with a per-byte enable; reads are combinational. Contents are never reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write strobe
//   be     in   [3:0] byte-lane enables (bit i covers bits 8i+7:8i)
//   addr   in   word index
//   wdata  in   [31:0] write data, already placed in its lanes
//   rdata  out  [31:0] word at addr
`timescale 1ns/1ps

module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [IDX_W-1:0]     addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder for a CPU load/store port
//
// Purpose: accepts one load/store at a time, waits WAIT_CYCLES, then presents a
// response held until the CPU takes it. Stores commit on the edge entering RESP.
// Optional build macro: DMEM_MISALIGN_CHECK_EN flags word accesses with
// addr[1:0]!=0 (rsp_err=1, rsp_rdata=0, store suppressed); without it rsp_err=0.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept
//   req_write  in   1=store, 0=load
//   req_mode   in   0=word, 1=byte
//   req_addr   in   [ADDR_WIDTH-1:0] byte address
//   req_wdata  in   [ADDR_WIDTH-1:0] store data (byte stores use [7:0])
//   rsp_valid  out  response present
//   rsp_ready  in   CPU accepts the response
//   rsp_rdata  out  [ADDR_WIDTH-1:0] load data, 0 for stores
//   rsp_err    out  misaligned word access
`timescale 1ns/1ps

module dmem_responder #(
  parameter int ADDR_WIDTH  = dmem_responder_pkg::ADDR_WIDTH,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  import dmem_responder_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  logic                  cap_write, cap_mode;
  logic [ADDR_WIDTH-1:0] cap_addr, cap_wdata;
  logic [ADDR_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // The request being served: live inputs while idle (so a zero-wait access can
  // complete on its accept edge), the captured copy otherwise.
  logic                  cur_write, cur_mode;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_wdata;

  logic                  accept;
  logic                  enter_resp;
  logic                  misaligned;
  logic [IDX_W-1:0]      word_idx;
  logic [3:0]            mem_be;
  logic [WORD_BITS-1:0]  mem_wdata;
  logic [WORD_BITS-1:0]  mem_rdata;
  logic [WORD_BITS-1:0]  load_word;
  logic                  mem_we;

  // Address bits above the storage window are deliberately ignored (wrap).
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^cur_addr[ADDR_WIDTH-1:IDX_W+2];

  assign cur_write = (state_q == ST_IDLE) ? req_write : cap_write;
  assign cur_mode  = (state_q == ST_IDLE) ? req_mode  : cap_mode;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : cap_addr;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : cap_wdata;

  // rst is folded in so that no store can slip into the array while reset is held.
  assign accept     = rst && (state_q == ST_IDLE) && req_valid;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      (rst && (state_q == ST_WAIT) && (cnt_q == 4'd0));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = (cur_mode == MODE_WORD) && (cur_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign word_idx  = cur_addr[IDX_W+1:2];
  assign mem_be    = (cur_mode == MODE_BYTE) ? byte_enable(cur_addr[1:0]) : 4'hF;
  assign mem_wdata = (cur_mode == MODE_BYTE) ? {4{cur_wdata[7:0]}} : cur_wdata[WORD_BITS-1:0];
  assign mem_we    = enter_resp && cur_write && !misaligned;

  assign load_word = (cur_mode == MODE_BYTE) ?
                     {24'd0, mem_rdata[8*cur_addr[1:0] +: 8]} : mem_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (word_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      cap_write <= 1'b0;
      cap_mode  <= MODE_WORD;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_write <= req_write;
        cap_mode  <= req_mode;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= (cur_write || misaligned) ? '0 : ADDR_WIDTH'(load_word);
        err_q   <= misaligned;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign req_ready = rst && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
